// File: rtl/sram_fifo_ctrl.sv
// FIFO controller wrapping a 16x8 single-port, synchronous-read SRAM.
// One SRAM access per cycle (reads win); a one-entry output register holds the head.
module sram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   mem_count_reg;
    logic              rd_inflight_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;

    logic rd_req;
    logic wr_en;
    logic pop;

    assign count = mem_count_reg
                 + {{ADDR_W{1'b0}}, rd_inflight_reg}
                 + {{ADDR_W{1'b0}}, out_valid_reg};
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Only one read may be outstanding, and only when its data has somewhere to land.
    assign rd_req = (mem_count_reg != '0) && !rd_inflight_reg
                 && (!out_valid_reg || out_ready);

    // Full is judged on the current count, ignoring a same-cycle pop.
    assign in_ready = rst_n && !rd_req && (count < DEPTH_C);
    assign wr_en    = in_valid && in_ready;
    assign pop      = out_valid_reg && out_ready;

    assign mem_address  = rd_req ? rd_ptr_reg : wr_ptr_reg;
    assign mem_write_en = wr_en;
    assign mem_data_in  = in_data;

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg    <= wr_ptr_reg + ONE_PTR;
                mem_count_reg <= mem_count_reg + ONE_CNT;
            end else if (rd_req) begin
                rd_ptr_reg    <= rd_ptr_reg + ONE_PTR;
                mem_count_reg <= mem_count_reg - ONE_CNT;
            end
        end
    end

    // A capture always lands in an empty or just-popped register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
        end else begin
            rd_inflight_reg <= rd_req;
            if (rd_inflight_reg) begin
                out_data_reg  <= mem_data_out;
                out_valid_reg <= 1'b1;
            end else if (pop) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: SRAM model, queue-based reference, vector table and sequences.
module tb_sram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic [3:0] mem_address;
    logic       mem_write_en;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // 16x8 single-port SRAM, registered read
    logic [7:0] sram [16];
    always @(posedge clk) begin
        if (mem_write_en) sram[mem_address] <= mem_data_in;
        else              mem_data_out <= sram[mem_address];
    end

    int n_vec = 0;
    int n_bad = 0;

    // reference: ordered contents of the FIFO, plus totals of accepted pushes/pops
    logic [7:0] q[$];
    int wr_total = 0;
    int rd_total = 0;
    int cyc = 0;
    logic last_push, last_pop, s_we, s_irdy;
    logic [7:0] last_pop_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after the falling edge with inputs applied; returns after next falling edge.
    task automatic cycle();
        logic push, pop;
        logic [7:0] pd;
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == 16));
        check("empty", 32'(empty), 32'(q.size() == 0));
        if (q.size() == 16) check("in_ready_when_full", 32'(in_ready), 0);
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        pd   = in_data;
        check("write_en", 32'(mem_write_en), 32'(push));
        if (push) check("write_addr", 32'(mem_address), 32'(wr_total % 16));
        if (out_valid) begin
            if (q.size() == 0) check("out_valid_when_empty", 32'(out_valid), 0);
            else               check("out_data_head", 32'(out_data), 32'(q[0]));
        end
        s_we = mem_write_en;
        s_irdy = in_ready;
        if (pop) last_pop_data = out_data;
        @(posedge clk);
        if (pop && q.size() != 0) begin
            void'(q.pop_front());
            rd_total++;
        end
        if (push) begin
            q.push_back(pd);
            wr_total++;
        end
        last_push = push;
        last_pop  = pop;
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_we;
        logic [3:0] e_addr;
        logic       e_ov;
        logic [7:0] e_od;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        int pops, prev_cyc, n, ok;
        logic alt_ok;

        // single push 0xA5 with out_ready low, then one pop
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 5'd0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 5'd1};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'd1};
        vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'hA5, 5'd1};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 8'hA5, 5'd1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'd0};

        // reset: outputs held inactive even with a push request present
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_write_en", 32'(mem_write_en), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_write_en", 32'(mem_write_en), 0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_irdy));
            check($sformatf("vec%0d_write_en", i), 32'(mem_write_en), 32'(vt[i].e_we));
            check($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vt[i].e_addr));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            if (vt[i].e_ov) check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].e_od));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            cycle();
        end

        // fill with 0x00..0x0F
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            n = 0;
            do begin cycle(); n++; end while (!last_push && n < 20);
            if (!last_push) check("fill_timeout", 0, 1);
        end
        in_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("overflow_refused", 32'(last_push), 0);
            check("full_in_ready", 32'(s_irdy), 0);
        end
        in_valid = 1'b0;
        #1;
        check("fill_count", 32'(count), 16);
        check("fill_full", 32'(full), 1);
        @(negedge clk);

        // drain: in order, one pop every 2 cycles
        out_ready = 1'b1;
        pops = 0; prev_cyc = 0; n = 0;
        while (pops < 16 && n < 100) begin
            cycle(); n++;
            if (last_pop) begin
                check("drain_order", 32'(last_pop_data), 32'(pops));
                if (pops > 0) check("drain_interval", 32'(cyc - prev_cyc), 2);
                prev_cyc = cyc;
                pops++;
            end
        end
        check("drain_pops", 32'(pops), 16);
        #1;
        check("drain_empty", 32'(empty), 1);
        @(negedge clk);

        // arbitration: SRAM holds entries, continuous push while popping
        out_ready = 1'b0; in_valid = 1'b1;
        n = 0;
        while (q.size() < 4 && n < 40) begin
            in_data = 8'($urandom); cycle(); n++;
        end
        check("arb_prefill", 32'(q.size()), 4);
        out_ready = 1'b1;
        cycle();
        alt_ok = s_we;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom);
            cycle();
            check("arb_alternate", 32'(s_we), 32'(!alt_ok));
            check("arb_in_ready", 32'(s_irdy), 32'(s_we));
            alt_ok = s_we;
        end
        in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0) && n < 100) begin cycle(); n++; end
        check("arb_drained", 32'(q.size()), 0);

        // random traffic with stalls, 40 bytes
        n = 0; ok = 0;
        begin
            int pushed, popped0;
            pushed = 0; popped0 = rd_total;
            while (n < 3000) begin
                in_valid  = (pushed < 40) && ($urandom_range(0, 3) != 0);
                in_data   = 8'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                cycle(); n++;
                if (last_push) pushed++;
                check("rand_count_bound", 32'(count <= 5'd16), 1);
                if (pushed == 40 && q.size() == 0) begin ok = 1; break; end
            end
            check("rand_complete", 32'(ok), 1);
            check("rand_pops", 32'(rd_total - popped0), 40);
        end

        // reset mid-operation with 9 entries held
        out_ready = 1'b0; in_valid = 1'b1;
        n = 0;
        while (q.size() < 9 && n < 60) begin
            in_data = 8'($urandom); cycle(); n++;
        end
        check("mid_prefill", 32'(q.size()), 9);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        q.delete(); wr_total = 0; rd_total = 0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        cycle();
        check("mid_push_accept", 32'(last_push), 1);
        in_valid = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!last_pop && n < 10);
        check("mid_pop_seen", 32'(last_pop), 1);
        check("mid_pop_data", 32'(last_pop_data), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
